// File: rtl/mul_pipe_ctrl.sv
// Two-stage pipelined multiplier controller (MUL / MULH / MULHU) with a valid/ready interface.
// Define MUL_PIPE_CTRL_SKID_EN to add a 1-entry input skid buffer that registers in_ready.

module mul_pipe_booth #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               unsign,
    output logic [2*WIDTH-1:0] product
);
    // Operands widened by two bits so one signed radix-4 array covers both signednesses.
    localparam int EW = WIDTH + 2;
    localparam int PW = 2 * WIDTH;
    localparam int ND = EW / 2;

    logic [EW-1:0] ax;
    logic [EW-1:0] bx;
    logic [EW:0]   bpad;
    logic [PW-1:0] ax_ext;
    logic [PW-1:0] pp;
    logic [PW-1:0] acc;
    logic [2:0]    trip;

    assign ax     = {{2{~unsign & a[WIDTH-1]}}, a};
    assign bx     = {{2{~unsign & b[WIDTH-1]}}, b};
    assign bpad   = {bx, 1'b0};
    assign ax_ext = {{(PW-EW){ax[EW-1]}}, ax};

    always_comb begin
        acc  = '0;
        pp   = '0;
        trip = '0;
        for (int i = 0; i < ND; i++) begin
            trip = bpad[2*i +: 3];
            case (trip)
                3'b001, 3'b010: pp = ax_ext;
                3'b011:         pp = ax_ext << 1;
                3'b100:         pp = -(ax_ext << 1);
                3'b101, 3'b110: pp = -ax_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2*i));
        end
    end

    assign product = acc;
endmodule

module mul_pipe_ctrl #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    // Handshake: a beat moves when valid and ready are both high at a rising edge; valid never
    // waits on ready, and an unaccepted output beat holds its data unchanged.

    logic             ready_en;
    logic             s1_valid;
    logic             s1_unsign;
    logic             s1_hi;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_xfer;
    logic             s1_adv;
    logic             s1_open;
    logic             s1_load;
    logic             accept;
    logic             skid_valid;
    logic [WIDTH-1:0] ld_a;
    logic [WIDTH-1:0] ld_b;
    logic [1:0]       ld_op;
    logic [TAG_W-1:0] ld_tag;
    logic [2*WIDTH-1:0] product;

    assign s2_xfer = s2_valid & out_ready;
    assign s1_adv  = s1_valid & (~s2_valid | s2_xfer);
    assign s1_open = ~s1_valid | s1_adv;

`ifdef MUL_PIPE_CTRL_SKID_EN
    logic [WIDTH-1:0] sk_a;
    logic [WIDTH-1:0] sk_b;
    logic [1:0]       sk_op;
    logic [TAG_W-1:0] sk_tag;

    // in_ready comes only from registers and flush, never from out_ready.
    assign in_ready = ready_en & ~skid_valid & ~flush;
    assign accept   = in_valid & in_ready;
    assign s1_load  = ~flush & s1_open & (skid_valid | accept);
    assign ld_a     = skid_valid ? sk_a   : in_a;
    assign ld_b     = skid_valid ? sk_b   : in_b;
    assign ld_op    = skid_valid ? sk_op  : in_op;
    assign ld_tag   = skid_valid ? sk_tag : in_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            sk_a       <= '0;
            sk_b       <= '0;
            sk_op      <= '0;
            sk_tag     <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (s1_open) skid_valid <= 1'b0;
        end else if (accept && !s1_open) begin
            skid_valid <= 1'b1;
            sk_a       <= in_a;
            sk_b       <= in_b;
            sk_op      <= in_op;
            sk_tag     <= in_tag;
        end
    end
`else
    assign skid_valid = 1'b0;
    assign in_ready   = ready_en & ~flush & s1_open;
    assign accept     = in_valid & in_ready;
    assign s1_load    = accept;
    assign ld_a       = in_a;
    assign ld_b       = in_b;
    assign ld_op      = in_op;
    assign ld_tag     = in_tag;
`endif

    // Keeps in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_unsign <= 1'b0;
            s1_hi     <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_tag    <= '0;
        end else begin
            if (flush)        s1_valid <= 1'b0;
            else if (s1_load) s1_valid <= 1'b1;
            else if (s1_adv)  s1_valid <= 1'b0;
            if (s1_load) begin
                s1_a      <= ld_a;
                s1_b      <= ld_b;
                s1_unsign <= (ld_op == 2'b11);
                s1_hi     <= ld_op[0];
                s1_tag    <= ld_tag;
            end
        end
    end

    mul_pipe_booth #(.WIDTH(WIDTH)) u_mul (
        .a       (s1_a),
        .b       (s1_b),
        .unsign  (s1_unsign),
        .product (product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
        end else begin
            if (flush)        s2_valid <= 1'b0;
            else if (s1_adv)  s2_valid <= 1'b1;
            else if (s2_xfer) s2_valid <= 1'b0;
            if (s1_adv && !flush) begin
                s2_result <= s1_hi ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
                s2_tag    <= s1_tag;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_tag    = s2_tag;
    assign busy       = s1_valid | s2_valid | skid_valid;
endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Self-checking bench for mul_pipe_ctrl: directed vector table, stall/flush/reset sequences
// and randomized traffic scored against an arithmetic reference model.

module tb_mul_pipe_ctrl;
    localparam int W  = 16;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [1:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic          busy;

    mul_pipe_ctrl #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] exp;
    } vec_t;

    vec_t          vecs[14];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            n_out = 0;
    logic [W+TW-1:0] exp_q[$];
    int            acc_q[$];
    logic [W-1:0]  next_exp;
    bit            lat_chk = 0;
    bit            stalled_prev = 0;
    logic [W-1:0]  prev_res;
    logic [TW-1:0] prev_tag;

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
        longint    sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            2'b01:   begin p = sa * sb; return p[2*W-1:W]; end
            2'b11:   begin p = ua * ub; return p[2*W-1:W]; end
            default: begin p = ua * ub; return p[W-1:0];   end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of traffic: sample handshakes at the negedge, score, then step to posedge+1.
    task automatic step(output bit acc);
        logic [W+TW-1:0] e;
        int              ac;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (stalled_prev)
            check("hold", {11'd0, out_valid, out_tag, out_result}, {11'd0, 1'b1, prev_tag, prev_res});
        if (flush) begin
            exp_q.delete();
            acc_q.delete();
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got tag %h result %h, required none", out_tag, out_result);
            end else begin
                e  = exp_q.pop_front();
                ac = acc_q.pop_front();
                check("result", {12'd0, out_tag, out_result}, {12'd0, e});
                if (lat_chk) check("latency", cyc - ac, 2);
                n_out++;
            end
        end
        if (acc) begin
            exp_q.push_back({in_tag, next_exp});
            acc_q.push_back(cyc);
        end
        stalled_prev = out_valid && !out_ready && !flush;
        prev_res = out_result;
        prev_tag = out_tag;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic [TW-1:0] tag, input logic [W-1:0] e);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        in_tag = tag;
        next_exp = e;
        for (int k = 0; k < 50 && !acc; k++) step(acc);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept, required accept of tag %h", tag);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) step(acc);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) step(acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           acc;
        int           t;
        int           base;
        int           n0;
        logic [W-1:0] ra, rb;
        logic [1:0]   rop;
        logic         r0;

        vecs[0]  = '{16'hFFFF, 16'hFFFF, 2'b00, 16'h0001};
        vecs[1]  = '{16'hFFFF, 16'hFFFF, 2'b01, 16'h0000};
        vecs[2]  = '{16'hFFFF, 16'hFFFF, 2'b11, 16'hFFFE};
        vecs[3]  = '{16'hFFFF, 16'hFFFF, 2'b10, 16'h0001};
        vecs[4]  = '{16'h8000, 16'h8000, 2'b01, 16'h4000};
        vecs[5]  = '{16'h8000, 16'h8000, 2'b11, 16'h4000};
        vecs[6]  = '{16'h8000, 16'h8000, 2'b00, 16'h0000};
        vecs[7]  = '{16'h1234, 16'h5678, 2'b00, 16'h0060};
        vecs[8]  = '{16'h1234, 16'h5678, 2'b11, 16'h0626};
        vecs[9]  = '{16'h1234, 16'h5678, 2'b01, 16'h0626};
        vecs[10] = '{16'h0003, 16'hFFFF, 2'b01, 16'hFFFF};
        vecs[11] = '{16'h0003, 16'hFFFF, 2'b11, 16'h0002};
        vecs[12] = '{16'h7FFF, 16'h8000, 2'b01, 16'hC000};
        vecs[13] = '{16'h7FFF, 16'h8000, 2'b10, 16'h8000};

        // Reset state
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        in_tag = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        next_exp = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_at_release", in_ready, 0);
        @(posedge clk);
        #1;
        check("in_ready_after_release", in_ready, 1);

        // Directed table, back-to-back with no backpressure
        out_ready = 1'b1;
        lat_chk = 1;
        for (int i = 0; i < 14; i++) send(vecs[i].a, vecs[i].b, vecs[i].op, TW'(i), vecs[i].exp);
        drain();
        lat_chk = 0;

        // Stream of 8 with out_ready low for relative cycles 3..6
        n0 = n_out;
        t = 0;
        base = cyc;
        for (int k = 0; k < 80 && (t < 8 || exp_q.size() > 0); k++) begin
            out_ready = !((cyc - base) >= 3 && (cyc - base) <= 6);
            if (t < 8) begin
                in_valid = 1'b1;
                in_a = W'($urandom);
                in_b = W'($urandom);
                in_op = 2'($urandom_range(0, 3));
                in_tag = TW'(t);
                next_exp = model(in_a, in_b, in_op);
            end else begin
                in_valid = 1'b0;
            end
            step(acc);
            if (acc) t++;
        end
        in_valid = 1'b0;
        check("stall_count", n_out - n0, 8);
        check("stall_empty", exp_q.size(), 0);

        // Flush with two requests in flight and a request presented
        out_ready = 1'b0;
        send(16'h0011, 16'h0022, 2'b00, 4'h8, model(16'h0011, 16'h0022, 2'b00));
        send(16'h0033, 16'h0044, 2'b00, 4'h9, model(16'h0033, 16'h0044, 2'b00));
        check("busy_before_flush", busy, 1);
        in_valid = 1'b1;
        in_a = 16'h0055;
        in_b = 16'h0066;
        in_op = 2'b00;
        in_tag = 4'hA;
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        step(acc);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_busy", busy, 0);
        out_ready = 1'b1;
        send(16'h0102, 16'h0304, 2'b11, 4'hB, model(16'h0102, 16'h0304, 2'b11));
        drain();
        idle(4);

        // Asynchronous reset mid-cycle with S2 holding a result
        out_ready = 1'b0;
        send(16'h00FF, 16'h0101, 2'b00, 4'hC, model(16'h00FF, 16'h0101, 2'b00));
        idle(2);
        check("s2_valid_before_rst", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        exp_q.delete();
        acc_q.delete();
        stalled_prev = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("in_ready_low_at_release", in_ready, 0);
        @(posedge clk);
        #1;
        check("in_ready_1cyc_after_release", in_ready, 1);
        out_ready = 1'b1;
        send(16'h0007, 16'h0009, 2'b00, 4'hD, 16'h003F);
        drain();
        idle(4);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ra = W'($urandom);
            rb = W'($urandom);
            rop = 2'($urandom_range(0, 3));
            in_a = ra;
            in_b = rb;
            in_op = rop;
            in_tag = TW'($urandom);
            next_exp = model(ra, rb, rop);
            step(acc);
        end
        drain();

`ifdef MUL_PIPE_CTRL_SKID_EN
        // Continuous stream, out_ready toggling each cycle; in_ready must not follow out_ready
        t = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 200 && t < 40; k++) begin
            in_valid = 1'b1;
            in_a = W'($urandom);
            in_b = W'($urandom);
            in_op = 2'($urandom_range(0, 3));
            in_tag = TW'(t);
            next_exp = model(in_a, in_b, in_op);
            out_ready = ~out_ready;
            #1;
            r0 = in_ready;
            out_ready = ~out_ready;
            #1;
            check("in_ready_indep_of_out_ready", in_ready, r0);
            out_ready = ~out_ready;
            #1;
            step(acc);
            if (acc) t++;
        end
        check("skid_stream_count", t, 40);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_pipe_ctrl.md
MUL_PIPE_CTRL -- requirements
Module: mul_pipe_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand and result width; the value is even and at least 8.
REQ-002 SHALL have parameter TAG_W, default 4, giving the width of the transaction tag.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an upstream request is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the request this cycle.
REQ-007 SHALL have ports in_a and in_b, input, WIDTH bits each: the operands.
REQ-008 SHALL have port in_op, input, 2 bits: 00 MUL (lower half), 01 MULH (signed x signed, upper half), 11 MULHU (unsigned x unsigned, upper half), 10 reserved.
REQ-009 SHALL have port in_tag, input, TAG_W bits: an opaque tag returned with the result.
REQ-010 SHALL have port flush, input, 1 bit: a synchronous discard of all in-flight work.
REQ-011 SHALL have port out_valid, output, 1 bit: a result is present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream takes the result.
REQ-013 SHALL have port out_result, output, WIDTH bits: the selected product half.
REQ-014 SHALL have port out_tag, output, TAG_W bits: the tag of the current result.
REQ-015 SHALL have port busy, output, 1 bit: any pipeline or skid entry is valid.

Function
REQ-016 SHALL accept a request when in_valid and in_ready are both high (handshake), and SHALL transfer a result when out_valid and out_ready are both high.
REQ-017 SHALL register operands, unsign and a result-select into stage S1 on accept; unsign = 1 for op 11, 0 otherwise.
REQ-018 SHALL compute the 2*WIDTH product with one instance of the team's booth-encoded WIDTHxWIDTH multiplier, fed from S1 registers only.
REQ-019 SHALL register the result into stage S2 on S1 advance: the lower half for ops 00/10, the upper half for ops 01/11.
REQ-020 SHALL treat op 10 exactly as op 00.
REQ-021 SHALL have a latency of 2 cycles: a request accepted in cycle N is presented with out_valid high in cycle N+2 when there is no backpressure.
REQ-022 SHALL sustain a throughput of 1 result per cycle while out_ready is held high.
REQ-023 SHALL advance S1 to S2 when S1 is valid and (S2 is empty or S2 is transferring in the same cycle).
REQ-024 SHALL hold out_result and out_tag stable while out_valid is high and out_ready is low.
REQ-025 SHALL, while flush is high, clear all valid bits at the next edge, force in_ready low and drop any request presented that cycle; flush has priority over accept and transfer.
REQ-026 SHALL drive busy high when S1, S2 or the skid entry is valid; busy is registered-state only.

Reset
REQ-027 SHALL, while rst is high, asynchronously clear the S1, S2 and skid valid bits, giving out_valid = 0 and busy = 0.
REQ-028 SHALL reset out_result and out_tag to 0.
REQ-029 SHALL hold in_ready low while rst is asserted, and SHALL release it in the first cycle after deassertion.
REQ-030 SHALL lose any transaction that is in flight when rst asserts mid-operation, with no partial output.

Configuration
REQ-031 SHALL, with macro MUL_PIPE_CTRL_SKID_EN defined, add a 1-entry skid buffer at the input, so that in_ready = ~skid_valid from a register with no combinational path from out_ready.
REQ-032 SHALL, with MUL_PIPE_CTRL_SKID_EN defined, capture a request accepted while S1 cannot load into the skid entry, and drain it into S1 with priority over new requests; ordering is preserved.
REQ-033 SHALL, without MUL_PIPE_CTRL_SKID_EN, drive in_ready = ~flush & (~S1_valid | S1_advance), combinationally dependent on out_ready, with no skid storage; latency is unchanged in both builds.

Verification
REQ-034 SHALL verify: a=0xFFFF, b=0xFFFF, ops 00/01/11 back-to-back, out_ready=1 -> results 0x0001, 0x0000, 0xFFFE on consecutive cycles starting 2 cycles after the first accept.
REQ-035 SHALL verify: a=0x8000, b=0x8000, op 01 -> 0x4000; a=0x1234, b=0x5678, op 00 -> 0x0060, op 11 -> 0x0626.
REQ-036 SHALL verify: 8 requests streamed, out_ready low for cycles 3-6 -> no loss or duplication, tags returned in order 0-7, outputs stable while stalled.
REQ-037 SHALL verify: flush pulsed with 2 requests in flight and in_valid high -> out_valid = 0 next cycle, busy = 0, the flushed tags never appear, and the next request completes normally.
REQ-038 SHALL verify: rst asserted asynchronously between edges with S2 valid -> out_valid and busy fall immediately; in_ready rises 1 cycle after release.
REQ-039 SHALL verify, with MUL_PIPE_CTRL_SKID_EN: out_ready toggled every cycle with a continuous input stream -> in_ready never depends combinationally on out_ready, and all results are correct and in order.
